// File: rtl/xeng_sched_pkg.sv
// xeng_sched_pkg: shared types and sizing helpers for the X-engine window scheduler
//   state_t            scheduler FSM states
//   n_taps / dump_len  tap-chain geometry derived from the antenna count
//   WIN_CNT_W/ERR_CNT_W  stats counter widths
package xeng_sched_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  localparam int WIN_CNT_W = 32;
  localparam int ERR_CNT_W = 16;
  function automatic int n_taps(input int n_ants);
    return n_ants / 2 + 1;
  endfunction
  function automatic int dump_len(input int n_ants);
    return n_taps(n_ants) * n_ants;
  endfunction
endpackage

// File: rtl/xeng_dump_timer.sv
// xeng_dump_timer: latency countdown plus dump-phase sequencer
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle pulse on the last sample of a completed window
//   dump_valid      dump phase active (DUMP_LEN cycles)
//   dump_idx        baseline slot being dumped, 0..DUMP_LEN-1
module xeng_dump_timer #(
  parameter int PIPE_LATENCY = 8,
  parameter int DUMP_LEN = 544
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        dump_valid,
  output logic [$clog2(DUMP_LEN)-1:0] dump_idx
);
  localparam int CW = $clog2(PIPE_LATENCY + 1);
  localparam int IW = $clog2(DUMP_LEN);
  localparam logic [CW-1:0] LAT = CW'(PIPE_LATENCY);
  localparam logic [IW-1:0] DUMP_LAST = IW'(DUMP_LEN - 1);
  logic [CW-1:0] cnt, cnt_n;
  logic pend, pend_n, expire, dlast, go;
  logic dump_valid_n;
  logic [IW-1:0] dump_idx_n;
  // An expiry that lands while a dump is still streaming parks in the single
  // pending slot and launches the moment the current dump finishes.
  always_comb begin
    expire = cnt == CW'(1);
    dlast = dump_valid && dump_idx == DUMP_LAST;
    go = (expire || pend) && (!dump_valid || dlast);
    pend_n = (expire || pend) && !go;
    cnt_n = start ? LAT : (cnt != '0 ? cnt - CW'(1) : cnt);
    dump_valid_n = go ? 1'b1 : (dlast ? 1'b0 : dump_valid);
    dump_idx_n = (go || dlast || !dump_valid) ? '0 : dump_idx + IW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      pend <= 1'b0;
      dump_valid <= 1'b0;
      dump_idx <= '0;
    end else begin
      cnt <= cnt_n;
      pend <= pend_n;
      dump_valid <= dump_valid_n;
      dump_idx <= dump_idx_n;
    end
  end
endmodule

// File: rtl/xeng_win_sched.sv
// xeng_win_sched: window scheduler for the head of the X-engine tap chain
//   clk, rst_n   clock, asynchronous active-low reset
//   sync_in      upstream sync, arms/re-arms and clears win_err
//   din_valid    sample present on the tap-chain input
//   tap_sync     pulse on the first sample of a window
//   ant_idx      antenna index of the sample
//   acc_idx      serial accumulation index of the sample
//   idx_valid    ant_idx/acc_idx qualify a window sample
//   dump_valid   dump phase active, dump_idx = baseline slot
//   win_err      sticky gap error
//   win_count    completed windows, err_count aborted windows (saturating)
// Build option: XENG_WIN_SCHED_STATS_EN implements win_count/err_count; otherwise they read 0.
module xeng_win_sched import xeng_sched_pkg::*; #(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int N_ANTS = 32,
  parameter int PIPE_LATENCY = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 sync_in,
  input  logic                                 din_valid,
  output logic                                 tap_sync,
  output logic [$clog2(N_ANTS)-1:0]            ant_idx,
  output logic [SERIAL_ACC_LEN_BITS-1:0]       acc_idx,
  output logic                                 idx_valid,
  output logic                                 dump_valid,
  output logic [$clog2(dump_len(N_ANTS))-1:0]  dump_idx,
  output logic                                 win_err,
  output logic [WIN_CNT_W-1:0]                 win_count,
  output logic [ERR_CNT_W-1:0]                 err_count
);
  localparam int AW = $clog2(N_ANTS);
  localparam int SB = SERIAL_ACC_LEN_BITS;
  localparam int N_TAPS = n_taps(N_ANTS);
  localparam int DUMP_LEN = N_TAPS * N_ANTS;
  localparam logic [AW-1:0] ANT_LAST = AW'(N_ANTS - 1);
  localparam logic [AW-1:0] ANT_PENULT = AW'(N_ANTS - 2);
  localparam logic [SB-1:0] ACC_LAST = '1;
  state_t state, state_n;
  logic bnd, start, adv, gap, done;
  // The index registers double as the window position: bnd means the last
  // accepted sample closed a window, so a pause there is legal.
  always_comb begin
    bnd = ant_idx == ANT_LAST && acc_idx == ACC_LAST;
    start = din_valid && (sync_in || state == ARMED || (state == RUN && bnd));
    adv = din_valid && !sync_in && state == RUN && !bnd;
    gap = !din_valid && !sync_in && state == RUN && !bnd;
    done = adv && ant_idx == ANT_PENULT && acc_idx == ACC_LAST;
    state_n = sync_in ? (din_valid ? RUN : ARMED)
            : state == IDLE ? IDLE
            : state == ARMED ? (din_valid ? RUN : ARMED)
            : gap ? ARMED : RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tap_sync <= 1'b0;
      idx_valid <= 1'b0;
      ant_idx <= '0;
      acc_idx <= '0;
      win_err <= 1'b0;
    end else begin
      state <= state_n;
      tap_sync <= start;
      idx_valid <= start || adv;
      ant_idx <= start ? '0 : adv ? (ant_idx == ANT_LAST ? '0 : ant_idx + AW'(1)) : ant_idx;
      acc_idx <= start ? '0 : (adv && ant_idx == ANT_LAST) ? acc_idx + SB'(1) : acc_idx;
      win_err <= sync_in ? 1'b0 : gap ? 1'b1 : win_err;
    end
  end
`ifdef XENG_WIN_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_count <= '0;
      err_count <= '0;
    end else begin
      win_count <= done ? win_count + WIN_CNT_W'(1) : win_count;
      err_count <= (gap && err_count != '1) ? err_count + ERR_CNT_W'(1) : err_count;
    end
  end
`else
  assign win_count = '0;
  assign err_count = '0;
`endif
  // Dumps run on their own schedule; aborts and sync_in never touch them.
  xeng_dump_timer #(
    .PIPE_LATENCY(PIPE_LATENCY),
    .DUMP_LEN(DUMP_LEN)
  ) u_dump_timer (
    .clk(clk),
    .rst_n(rst_n),
    .start(done),
    .dump_valid(dump_valid),
    .dump_idx(dump_idx)
  );
endmodule

// File: tb/tb_xeng_win_sched.sv
// tb_xeng_win_sched: scoreboard bench for xeng_win_sched (N_ANTS=4, SAL=4, PIPE_LATENCY=3)
module tb_xeng_win_sched;
`ifdef XENG_WIN_SCHED_STATS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, sync_in = 1'b0, din_valid = 1'b0;
  logic tap_sync, idx_valid, dump_valid, win_err;
  logic [1:0] ant_idx, acc_idx;
  logic [3:0] dump_idx;
  logic [31:0] win_count;
  logic [15:0] err_count;

  xeng_win_sched #(.SERIAL_ACC_LEN_BITS(2), .N_ANTS(4), .PIPE_LATENCY(3)) dut (
    .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .din_valid(din_valid),
    .tap_sync(tap_sync), .ant_idx(ant_idx), .acc_idx(acc_idx), .idx_valid(idx_valid),
    .dump_valid(dump_valid), .dump_idx(dump_idx), .win_err(win_err),
    .win_count(win_count), .err_count(err_count)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; logic tap; logic [1:0] ant; logic [1:0] acc;} ie_t;
  typedef struct {int c; logic [3:0] idx;} de_t;
  typedef struct {int c; logic zero; logic werr; logic [31:0] wc; logic [15:0] ec;} se_t;
  ie_t iq[$];
  de_t dq[$];
  se_t sq[$];
  ie_t ie;
  de_t de;
  se_t se;
  int total = 0, bad = 0;
  bit done = 1'b0, fin = 1'b0;

  // Monitor: pops expectations whenever the DUT presents output.
  always @(negedge clk) begin
    if (idx_valid || tap_sync) begin
      total++;
      if (iq.size() == 0) begin
        bad++;
        $display("FAIL idx: unexpected sample cyc=%0d tap=%0d ant=%0d acc=%0d iv=%0d", cyc, tap_sync, ant_idx, acc_idx, idx_valid);
      end else begin
        ie = iq.pop_front();
        if (!idx_valid || cyc != ie.c || tap_sync != ie.tap || ant_idx != ie.ant || acc_idx != ie.acc) begin
          bad++;
          $display("FAIL idx: got cyc=%0d iv=%0d tap=%0d ant=%0d acc=%0d want cyc=%0d iv=1 tap=%0d ant=%0d acc=%0d",
                   cyc, idx_valid, tap_sync, ant_idx, acc_idx, ie.c, ie.tap, ie.ant, ie.acc);
        end
      end
    end
    if (dump_valid) begin
      total++;
      if (dq.size() == 0) begin
        bad++;
        $display("FAIL dump: unexpected dump cyc=%0d idx=%0d", cyc, dump_idx);
      end else begin
        de = dq.pop_front();
        if (cyc != de.c || dump_idx != de.idx) begin
          bad++;
          $display("FAIL dump: got cyc=%0d idx=%0d want cyc=%0d idx=%0d", cyc, dump_idx, de.c, de.idx);
        end
      end
    end
    while (sq.size() > 0 && sq[0].c <= cyc) begin
      se = sq.pop_front();
      total++;
      if (se.c != cyc) begin
        bad++;
        $display("FAIL status: check for cyc=%0d missed at cyc=%0d", se.c, cyc);
      end else if (se.zero) begin
        if ({tap_sync, ant_idx, acc_idx, idx_valid, dump_valid, dump_idx, win_err, win_count, err_count} != '0) begin
          bad++;
          $display("FAIL zero@%0d: got tap=%0d ant=%0d acc=%0d iv=%0d dv=%0d di=%0d err=%0d wc=%0d ec=%0d want all 0",
                   cyc, tap_sync, ant_idx, acc_idx, idx_valid, dump_valid, dump_idx, win_err, win_count, err_count);
        end
      end else if (win_err != se.werr || win_count != se.wc || err_count != se.ec) begin
        bad++;
        $display("FAIL status@%0d: got err=%0d wc=%0d ec=%0d want err=%0d wc=%0d ec=%0d",
                 cyc, win_err, win_count, err_count, se.werr, se.wc, se.ec);
      end
    end
    if (done && !fin) begin
      fin = 1'b1;
      total++;
      if (iq.size() != 0 || dq.size() != 0 || sq.size() != 0) begin
        bad++;
        $display("FAIL drain: pending idx=%0d dump=%0d status=%0d want 0 0 0", iq.size(), dq.size(), sq.size());
      end
    end
  end

  task automatic drive(input logic s, input logic v);
    @(posedge clk);
    #1;
    sync_in = s;
    din_valid = v;
  endtask

  // Drives n consecutive samples with window positions first..first+n-1.
  task automatic run(input int first, input int n, input logic s0);
    for (int k = 0; k < n; k++) begin
      int i = first + k;
      drive(k == 0 && s0, 1'b1);
      iq.push_back('{cyc + 1, i == 0, 2'(i % 4), 2'(i / 4)});
      if (i == 15)
        for (int d = 0; d < 12; d++) dq.push_back('{cyc + 4 + d, 4'(d)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic chk(input logic we, input int wc, input int ec);
    sq.push_back('{cyc + 1, 1'b0, we, ST ? 32'(wc) : 32'd0, ST ? 16'(ec) : 16'd0});
  endtask

  task automatic zero(input int off);
    sq.push_back('{cyc + off, 1'b1, 1'b0, 32'd0, 16'd0});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    zero(0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // IDLE ignores samples
    drive(1'b0, 1'b1);
    zero(1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    zero(1);
    drive(1'b0, 1'b0);
    // arm, window, legal pause at boundary, two back-to-back windows
    drive(1'b1, 1'b0);
    idle(1);
    run(0, 16, 1'b0);
    idle(5);
    chk(1'b0, 1, 0);
    run(0, 16, 1'b0);
    run(0, 16, 1'b0);
    // gap at the 7th sample aborts
    run(0, 6, 1'b0);
    idle(1);
    chk(1'b1, 3, 1);
    idle(2);
    chk(1'b1, 3, 1);
    // fresh window after abort, then sync with sample mid-window during its dump
    run(0, 16, 1'b0);
    run(0, 5, 1'b0);
    run(0, 1, 1'b1);
    chk(1'b0, 4, 1);
    run(1, 3, 1'b0);
    drive(1'b1, 1'b0);
    chk(1'b0, 4, 1);
    idle(12);
    // reset in the middle of a dump
    drive(1'b1, 1'b0);
    run(0, 16, 1'b0);
    idle(7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    dq.delete();
    zero(0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b1);
    zero(1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    chk(1'b0, 0, 0);
    run(0, 1, 1'b1);
    run(1, 2, 1'b0);
    drive(1'b1, 1'b0);
    idle(20);
    done = 1'b1;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xeng_win_sched.md
# xeng_win_sched

Window scheduler for the X-engine tap chain. It tracks the contiguous antenna-sample stream feeding the first correlator tap and issues the start-of-window sync pulse that resets the taps' serial accumulators. It also provides the per-sample antenna and accumulation indices. After each completed window it opens a dump phase that the output mux uses to pull accumulated baselines off the tap shift register. It sits between the input reorder buffer and the head of the tap chain.

## Interface
- SERIAL_ACC_LEN_BITS, 7, log2 of serial accumulation length (SAL = 2^bits)
- N_ANTS, 32, antennas per time step, even, ≥4
- PIPE_LATENCY, 8, cycles from the last window sample to the first dump cycle, ≥1
- localparam N_TAPS = N_ANTS/2+1; DUMP_LEN = N_TAPS*N_ANTS; WIN_LEN = SAL*N_ANTS; requires DUMP_LEN ≤ WIN_LEN

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sync_in  in  1  upstream sync; arms/re-arms the scheduler
- din_valid  in  1  sample present on tap-chain input this cycle
- tap_sync  out  1  one-cycle pulse marking the first sample of a window
- ant_idx  out  clog2(N_ANTS)  antenna index of the sample
- acc_idx  out  SERIAL_ACC_LEN_BITS  serial accumulation index of the sample
- idx_valid  out  1  ant_idx/acc_idx qualify a window sample
- dump_valid  out  1  dump phase active
- dump_idx  out  clog2(DUMP_LEN)  baseline slot being dumped
- win_err  out  1  sticky gap error, cleared by sync_in
- win_count  out  32  completed windows (stats only)
- err_count  out  16  aborted windows, saturating (stats only)

## Operation
- States: IDLE, ARMED, RUN. Reset → IDLE. All outputs are 0 in reset.
- IDLE: din_valid is ignored. sync_in → ARMED.
- ARMED: the first din_valid starts a window. ant_idx=0, acc_idx=0, tap_sync=1, then → RUN.
- RUN: each din_valid advances ant_idx. On wrap from N_ANTS-1 to 0, acc_idx increments.
- Last sample: ant_idx=N_ANTS-1 and acc_idx=SAL-1.
  - The window completes and win_count increments.
  - The next din_valid starts a new window with tap_sync=1, staying in RUN (back-to-back windows).
- Gap: din_valid=0 in RUN while not on a window boundary.
  - The window is aborted, win_err is set, err_count increments, then → ARMED.
  - No dump is scheduled for the aborted window.
- din_valid=0 exactly at a window boundary is not an error. The scheduler stays in RUN and waits.
- sync_in in any state:
  - Aborts the current window with no error and clears win_err.
  - If din_valid is asserted in the same cycle, that sample starts a new window (tap_sync=1, → RUN). Otherwise → ARMED.
  - sync_in has priority over gap detection.
- Dump timer:
  - A completed window loads a countdown of PIPE_LATENCY. At expiry, dump_valid is high for DUMP_LEN cycles with dump_idx counting 0..DUMP_LEN-1.
  - Aborts and sync_in do not cancel a pending or active dump.
  - A dump armed while the previous one is still counting is legal only because DUMP_LEN ≤ WIN_LEN. The timer holds one pending entry.

## Timing
- All outputs are registered.
- tap_sync, ant_idx, acc_idx and idx_valid appear 1 cycle after the qualifying din_valid.
- First dump_valid: PIPE_LATENCY+1 cycles after the din_valid of the last window sample.
- win_err and the counters update 1 cycle after the causing event.
- Asynchronous reset mid-window or mid-dump clears everything immediately. No dump resumes after reset.

## Configuration
- XENG_WIN_SCHED_STATS_EN defined: win_count and err_count are implemented.
- Undefined: win_count and err_count are tied to 0 and their counters are not synthesized. win_err is always present.

## Structure
- Package xeng_sched_pkg holds:
  - the state enum
  - the N_TAPS/DUMP_LEN helper functions
  - the stats counter width constants
- Sub-module xeng_dump_timer holds:
  - the latency countdown
  - the single pending slot
  - the dump_idx counter
  - it takes a one-cycle start pulse.

## Test plan
Bench parameters: N_ANTS=4, SERIAL_ACC_LEN_BITS=2, PIPE_LATENCY=3 (WIN_LEN=16, DUMP_LEN=12).
- sync_in at cycle 0, din_valid continuous from cycle 2:
  - tap_sync at 3 and 19.
  - ant_idx cycles 0..3, acc_idx steps 0..3.
  - dump_valid on cycles 21–32 (dump_idx 0..11), next dump on 37–48.
- Gap: din_valid low at the 7th sample of a window:
  - win_err=1 and err_count=1 one cycle later.
  - No dump for that window.
  - The next valid gives tap_sync=1 with indices 0.
- Gap exactly at a window boundary (valid drops after the 16th sample for 5 cycles): no win_err. The resumed sample gives tap_sync=1.
- sync_in and din_valid together mid-window:
  - tap_sync=1 and ant_idx=0 next cycle.
  - win_err is cleared.
  - The dump from the earlier completed window still runs its full 12 cycles.
- rst_n low during a dump: all outputs 0 asynchronously. After release the block is in IDLE and ignores din_valid until sync_in.
- Stats build with the macro defined: 3 complete windows plus 1 abort gives win_count=3, err_count=1. Without the macro, both read 0.
